hilo_unit: RTL and testbench
============================

# hilo_unit

HI/LO register stage that sits directly downstream of the combinational multiplier in the MIPS CPU datapath. It captures the multiplier's 64-bit `{hi, lo}` product, and serves `mthi`/`mtlo` writes and `mfhi`/`mflo` reads. It also performs `madd`/`msub`-style accumulation through a two-stage pipeline with a valid/ready stall handshake to the decode/execute control.

## Interface

Parameters:
- `WIDTH`, default 32: width of HI, LO, the product halves and the GPR operand.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  request present this cycle.
- `op_ready`  out  1  block can accept; a request transfers when `op_valid & op_ready`.
- `op`  in  3  operation code (see hilo_pkg).
- `prod_hi`  in  WIDTH  multiplier high half.
- `prod_lo`  in  WIDTH  multiplier low half.
- `rs_data`  in  WIDTH  GPR operand for MTHI/MTLO.
- `rd_sel`  in  1  read select: 0 = LO, 1 = HI.
- `rd_data`  out  WIDTH  `mfhi`/`mflo` result (combinational).
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.
- `busy`  out  1  accumulate in flight.

## Operation

Op codes:
- 0 NOP
- 1 WR_PROD: `{hi, lo} <= {prod_hi, prod_lo}`
- 2 MTHI: `hi <= rs_data`
- 3 MTLO: `lo <= rs_data`
- 4 ACC_ADD: `{hi, lo} <= {hi, lo} + {prod_hi, prod_lo}`
- 5 ACC_SUB: `{hi, lo} <= {hi, lo} - {prod_hi, prod_lo}`
- 6 and 7: treated as NOP.

Arithmetic and signedness:
- Accumulate arithmetic is 2·WIDTH-bit modular; the carry/borrow out of bit 2·WIDTH-1 is discarded.
- Signed vs unsigned is resolved upstream by the multiplier's product. ACC_ADD and ACC_SUB therefore serve both `madd`/`maddu` and `msub`/`msubu`.

Accumulate pipeline:
- States: IDLE, ACC (one pending stage register).
- An accepted ACC_ADD or ACC_SUB latches the product and the add/sub flag into the stage register and moves IDLE→ACC.
- In ACC, the 64-bit result is written to `{hi, lo}` at the clock edge, then the block returns to IDLE.
- `op_ready` = `~busy` = (state == IDLE).
- A request presented while not ready is not consumed; upstream holds `op`, the product and `rs_data` stable.

Read port:
- `rd_data` selects HI or LO according to `rd_sel`.
- Same-cycle bypass: if a WR_PROD, MTHI or MTLO transfers in the same cycle and writes the selected register, `rd_data` returns the new value.
- No bypass exists for an accumulate. Control stalls `mfhi`/`mflo` while `busy` is high.

Reset:
- Asserting `rst_n` low, at any time including mid-accumulate, clears HI, LO and the stage register to 0, forces IDLE, and discards any pending accumulate.
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `op_ready` = 1, `rd_data` = 0.

## Timing

- WR_PROD, MTHI, MTLO accepted in cycle N: the register updates at the end of N and is visible on `hi`/`lo` in N+1. These ops have zero stall cycles.
- ACC accepted in cycle N:
  - `busy` = 1 and `op_ready` = 0 in N+1.
  - `{hi, lo}` is updated at the end of N+1 and valid in N+2.
  - The earliest next acceptance is N+2.
- Back-to-back accumulates therefore sustain one per 2 cycles.
- When a write would coincide with a pending accumulate, the pending accumulate always completes first; no other write can occur in ACC because `op_ready` is low.

## Configuration

- `HILO_ACC_EN` defined: accumulate pipeline, ACC_ADD/ACC_SUB and `busy` behave as specified above.
- `HILO_ACC_EN` undefined:
  - Op codes 4 and 5 are NOP.
  - The stage register and state machine are removed.
  - `busy` is tied 0 and `op_ready` is tied 1.

## Structure

- `hilo_pkg` holds:
  - the `hilo_op_e` op-code enum (3-bit, values above);
  - localparam `HILO_W` = 32;
  - the FSM state enum.
- Sub-module `hilo_acc` contains the stage register plus the 2·WIDTH-bit add/subtract. It is instantiated only under `HILO_ACC_EN`.

## Test plan

- Reset, then WR_PROD with prod = `{32'h1234_5678, 32'h9ABC_DEF0}` → next cycle `hi` = 32'h1234_5678, `lo` = 32'h9ABC_DEF0, `busy` = 0 throughout.
- MTLO with rs_data = 32'hDEAD_BEEF and `rd_sel` = 0 in the same cycle → `rd_data` = 32'hDEAD_BEEF via bypass; `hi` is unchanged.
- `{hi, lo}` = `{0, 32'hFFFF_FFFF}`, then ACC_ADD with prod = `{0, 1}` → `busy` = 1 for exactly one cycle, then `hi` = 1 and `lo` = 0 (carry across halves).
- `{hi, lo}` = 0, then ACC_SUB with prod = `{0, 1}` → `hi` = `lo` = 32'hFFFF_FFFF; a second ACC held on `op_valid` during the busy cycle is accepted exactly 2 cycles after the first.
- Assert `rst_n` low in the busy cycle of an ACC_ADD → `hi` = `lo` = 0, `busy` = 0 and `op_ready` = 1 immediately; no late write after release.
- Build without `HILO_ACC_EN`, issue ACC_ADD → `hi`/`lo` unchanged and `op_ready` stays 1.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO register stage: op codes, FSM states and default width.
// Accumulate support is enabled by defining HILO_ACC_EN.
package hilo_pkg;

  localparam int HILO_W = 32;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_WR_PROD = 3'd1,
    OP_MTHI    = 3'd2,
    OP_MTLO    = 3'd3,
    OP_ACC_ADD = 3'd4,
    OP_ACC_SUB = 3'd5
  } hilo_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } hilo_state_e;

endpackage

// File: rtl/hilo_acc.sv
// Accumulate stage: latches the product and the add/sub flag, then produces {hi,lo} +/- product one cycle later.
// Latency: write strobe one cycle after start; busy for that cycle (no further start accepted).
module hilo_acc
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               sub_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic               busy_o,
  output logic               wr_o,
  output logic [2*WIDTH-1:0] res_o
);

  hilo_state_e        state_q, state_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               sub_q, sub_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prod_q  <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    sub_d   = sub_q;
    busy_o  = 1'b0;
    wr_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACC;
          prod_d  = prod_i;
          sub_d   = sub_i;
        end
      end
      ST_ACC: begin
        busy_o  = 1'b1;
        wr_o    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // {hi,lo} cannot change while in ACC, so acc_i is the pre-accumulate value here.
  assign res_o = sub_q ? (acc_i - prod_q) : (acc_i + prod_q);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register stage behind the multiplier: product capture, mthi/mtlo writes, bypassed mfhi/mflo reads.
// Optional madd/msub accumulate pipeline under HILO_ACC_EN (2-cycle occupancy, op_ready low while busy).
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] prod_hi,
  input  logic [WIDTH-1:0] prod_lo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   hi_wr_val, lo_wr_val;
  logic               wr_hi, wr_lo;
  logic               accept;
  logic               acc_wr;
  logic [2*WIDTH-1:0] acc_res;

  assign accept = op_valid & op_ready;

  always_comb begin
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    hi_wr_val = prod_hi;
    lo_wr_val = prod_lo;
    if (accept) begin
      case (op)
        OP_WR_PROD: begin
          wr_hi = 1'b1;
          wr_lo = 1'b1;
        end
        OP_MTHI: begin
          wr_hi     = 1'b1;
          hi_wr_val = rs_data;
        end
        OP_MTLO: begin
          wr_lo     = 1'b1;
          lo_wr_val = rs_data;
        end
        default: ;
      endcase
    end
  end

`ifdef HILO_ACC_EN
  logic acc_start;

  assign acc_start = accept & ((op == OP_ACC_ADD) | (op == OP_ACC_SUB));

  hilo_acc #(.WIDTH(WIDTH)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (acc_start),
    .sub_i   (op == OP_ACC_SUB),
    .prod_i  ({prod_hi, prod_lo}),
    .acc_i   ({hi_q, lo_q}),
    .busy_o  (busy),
    .wr_o    (acc_wr),
    .res_o   (acc_res)
  );

  assign op_ready = ~busy;
`else
  assign busy     = 1'b0;
  assign op_ready = 1'b1;
  assign acc_wr   = 1'b0;
  assign acc_res  = '0;
`endif

  // acc_wr only occurs while op_ready is low, so it never collides with a direct write.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (acc_wr) begin
      {hi_d, lo_d} = acc_res;
    end else begin
      if (wr_hi) hi_d = hi_wr_val;
      if (wr_lo) lo_d = lo_wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign rd_data = rd_sel ? (wr_hi ? hi_wr_val : hi_q)
                          : (wr_lo ? lo_wr_val : lo_q);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit; accumulate scenarios run when HILO_ACC_EN is defined,
// otherwise the bench checks that accumulate op codes behave as NOPs.
module tb_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op;
  logic [W-1:0] prod_hi, prod_lo, rs_data;
  logic         rd_sel;
  logic [W-1:0] rd_data, hi, lo;
  logic         busy;

  int errors = 0;
  int checks = 0;

  hilo_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo),
    .rs_data  (rs_data),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Present a request at the falling edge, let it transfer at the next rising edge, then drop it.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] ph, input logic [W-1:0] pl,
                       input logic [W-1:0] rs);
    @(negedge clk);
    op_valid = 1'b1; op = o; prod_hi = ph; prod_lo = pl; rs_data = rs;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op_valid = 1'b0; op = 3'd0;
    prod_hi = '0; prod_lo = '0; rs_data = '0; rd_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", op_ready); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want %h", rd_data, 32'h0); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_wr_prod;
    @(negedge clk);
    op_valid = 1'b1; op = 3'd1; prod_hi = 32'h1234_5678; prod_lo = 32'h9ABC_DEF0; rd_sel = 1'b1;
    #1;
    checks++; if (rd_data !== 32'h1234_5678) begin errors++; $display("FAIL wrprod_bypass_hi got %h want %h", rd_data, 32'h1234_5678); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrprod_busy_pre got %b want 0", busy); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL wrprod_hi got %h want %h", hi, 32'h1234_5678); end
    checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL wrprod_lo got %h want %h", lo, 32'h9ABC_DEF0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrprod_busy_post got %b want 0", busy); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL wrprod_ready got %b want 1", op_ready); end
  endtask

  task automatic test_mtlo_bypass;
    @(negedge clk);
    op_valid = 1'b1; op = 3'd3; rs_data = 32'hDEAD_BEEF; rd_sel = 1'b0;
    prod_hi = 32'h5555_5555; prod_lo = 32'hAAAA_AAAA;
    #1;
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_bypass got %h want %h", rd_data, 32'hDEAD_BEEF); end
    checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_lo_pre got %h want %h", lo, 32'h9ABC_DEF0); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    checks++; if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_lo got %h want %h", lo, 32'hDEAD_BEEF); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got %h want %h", hi, 32'h1234_5678); end
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mflo_read got %h want %h", rd_data, 32'hDEAD_BEEF); end
  endtask

  task automatic test_mthi;
    @(negedge clk);
    op_valid = 1'b1; op = 3'd2; rs_data = 32'hCAFE_0001; rd_sel = 1'b0;
    #1;
    // Selected register is LO, which MTHI does not write: no bypass.
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_no_bypass_lo got %h want %h", rd_data, 32'hDEAD_BEEF); end
    rd_sel = 1'b1;
    #1;
    checks++; if (rd_data !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi_bypass got %h want %h", rd_data, 32'hCAFE_0001); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    checks++; if (hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi_hi got %h want %h", hi, 32'hCAFE_0001); end
    checks++; if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_lo_kept got %h want %h", lo, 32'hDEAD_BEEF); end
  endtask

  task automatic test_nop_ops;
    logic [2:0] nops [4];
    nops[0] = 3'd0; nops[1] = 3'd6; nops[2] = 3'd7; nops[3] = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_valid = (i != 3); op = nops[i];
      prod_hi = 32'h0BAD_0000 + i; prod_lo = 32'h0BAD_1000 + i; rs_data = 32'h0BAD_2000 + i;
      @(posedge clk); #1;
      op_valid = 1'b0; op = 3'd0;
      checks++; if (hi !== 32'hCAFE_0001) begin errors++; $display("FAIL nop%0d_hi got %h want %h", i, hi, 32'hCAFE_0001); end
      checks++; if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nop%0d_lo got %h want %h", i, lo, 32'hDEAD_BEEF); end
    end
  endtask

`ifdef HILO_ACC_EN
  task automatic test_acc_carry;
    issue(3'd1, 32'h0, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; prod_hi = 32'h0; prod_lo = 32'h1; rd_sel = 1'b1;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL acc_ready_pre got %b want 1", op_ready); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL acc_busy got %b want 1", busy); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL acc_ready_busy got %b want 0", op_ready); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL acc_no_bypass got %h want %h", rd_data, 32'h0); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL acc_busy_done got %b want 0", busy); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL acc_carry_hi got %h want %h", hi, 32'h1); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL acc_carry_lo got %h want %h", lo, 32'h0); end
  endtask

  task automatic test_back_to_back;
    issue(3'd1, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    op_valid = 1'b1; op = 3'd5; prod_hi = 32'h0; prod_lo = 32'h1;
    @(posedge clk); #1;
    // Second request presented from N+1 and held until it transfers.
    op = 3'd4; prod_hi = 32'h0; prod_lo = 32'h3;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_n1 got %b want 0", op_ready); end
    @(posedge clk); #1;
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_borrow_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_borrow_lo got %h want %h", lo, 32'hFFFF_FFFF); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_n2 got %b want 1", op_ready); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_n3 got %b want 1", busy); end
    @(posedge clk); #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL b2b_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h2) begin errors++; $display("FAIL b2b_lo got %h want %h", lo, 32'h2); end
  endtask

  task automatic test_reset_mid_acc;
    issue(3'd1, 32'h5, 32'h6, 32'h0);
    issue(3'd4, 32'h1, 32'h1, 32'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_acc_busy_pre got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_acc_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_acc_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_acc_busy got %b want 0", busy); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_acc_ready got %b want 1", op_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_acc_late_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_acc_late_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_acc_late_busy got %b want 0", busy); end
  endtask
`else
  task automatic test_acc_disabled;
    issue(3'd1, 32'h0, 32'hFFFF_FFFF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op_valid = 1'b1; op = (i == 0) ? 3'd4 : 3'd5; prod_hi = 32'h0; prod_lo = 32'h1;
      @(posedge clk); #1;
      op_valid = 1'b0; op = 3'd0;
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL accdis%0d_ready got %b want 1", i, op_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL accdis%0d_busy got %b want 0", i, busy); end
      @(posedge clk); #1;
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL accdis%0d_hi got %h want %h", i, hi, 32'h0); end
      checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL accdis%0d_lo got %h want %h", i, lo, 32'hFFFF_FFFF); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wr_prod();
    test_mtlo_bypass();
    test_mthi();
    test_nop_ops();
`ifdef HILO_ACC_EN
    test_acc_carry();
    test_back_to_back();
    test_reset_mid_acc();
`else
    test_acc_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
